palette_stage: RTL and testbench

PALETTE_STAGE -- requirements
Module: palette_stage

---
 rtl/palette_stage.sv | 166 ++++++++++++++++
 tb/tb_palette_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_stage.sv
// Palette lookup stage: converts colour indices into {R,G,B} entries through
// banked palette RAM. A default greyscale ramp is loaded after reset, and the
// video path is a two-stage pipeline that advances on the pixel clock enable.
module palette_stage #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CH_W  = 6,
    parameter int unsigned BANKS = 2,
    localparam int unsigned BK_W  = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int unsigned ENT_W = 3 * CH_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce_pix,
    input  logic             i_pixel,
    input  logic [IDX_W-1:0] i_color,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_mono,
    input  logic [BK_W-1:0]  i_bank_sel,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [BK_W-1:0]  i_wr_bank,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [ENT_W-1:0] i_wr_data,
    output logic [ENT_W-1:0] o_rgb,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_init_done
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = BK_W + IDX_W;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(BANKS * DEPTH - 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_init_cnt;

    logic [ENT_W-1:0]   r_pal [BANKS][DEPTH];

    logic [BK_W-1:0]    r_bank;
    logic [IDX_W-1:0]   r_s1_color;
    logic               r_s1_pixel;
    logic               r_s1_hsync;
    logic               r_s1_vsync;
    logic [ENT_W-1:0]   r_rgb;
    logic               r_hsync;
    logic               r_vsync;

    logic [BK_W-1:0]    w_init_bank;
    logic [IDX_W-1:0]   w_init_addr;
    logic [CH_W-1:0]    w_def_chan;
    logic               w_we;
    logic [BK_W-1:0]    w_we_bank;
    logic [IDX_W-1:0]   w_we_addr;
    logic [ENT_W-1:0]   w_we_data;
    logic [ENT_W-1:0]   w_rd_entry;
    logic [CH_W-1:0]    w_rd_g;
    logic [ENT_W-1:0]   w_rgb_next;

    // The init counter walks bank-major: upper bits select the bank, lower bits the address.
    assign w_init_bank = r_init_cnt[CNT_W-1:IDX_W];
    assign w_init_addr = r_init_cnt[IDX_W-1:0];

    // Default channel value: index left-aligned in the channel, or truncated to its MSBs.
    if (CH_W >= IDX_W) begin : g_def_wide
        assign w_def_chan = CH_W'(w_init_addr) << (CH_W - IDX_W);
    end else begin : g_def_narrow
        assign w_def_chan = w_init_addr[IDX_W-1 -: CH_W];
    end

    // Init/run sequencer: one default entry per clock, then run forever.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StInit;
            r_init_cnt <= '0;
        end else begin
            unique case (r_state)
                StInit: begin
                    if (r_init_cnt == INIT_LAST) begin
                        r_state <= StRun;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                StRun: begin
                    r_state <= StRun;
                end
                default: begin
                    r_state <= StInit;
                end
            endcase
        end
    end

    assign o_wr_ready  = (r_state == StRun);
    assign o_init_done = (r_state == StRun);

    // Single palette write port: default loader during init, host writes during run.
    always_comb begin
        w_we      = 1'b0;
        w_we_bank = w_init_bank;
        w_we_addr = w_init_addr;
        w_we_data = {3{w_def_chan}};
        if (r_state == StInit) begin
            w_we = 1'b1;
        end else if (i_wr_valid && (32'(i_wr_bank) < BANKS)) begin
            // Out-of-range banks are still handshaken but never written.
            w_we      = 1'b1;
            w_we_bank = i_wr_bank;
            w_we_addr = i_wr_addr;
            w_we_data = i_wr_data;
        end
    end

    // Palette storage; no reset since init rewrites every entry.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_pal[w_we_bank][w_we_addr] <= w_we_data;
        end
    end

    // Nonblocking write plus this read gives read-first behaviour on collisions.
    assign w_rd_entry = r_pal[r_bank][r_s1_color];
    assign w_rd_g     = w_rd_entry[2*CH_W-1:CH_W];

    // Stage-2 colour: black while initialising or outside active display.
    always_comb begin
        w_rgb_next = '0;
        if ((r_state == StRun) && r_s1_pixel) begin
            w_rgb_next = i_mono ? {3{w_rd_g}} : w_rd_entry;
        end
    end

    // Two-stage video pipeline and vsync-synchronised bank switch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bank     <= '0;
            r_s1_color <= '0;
            r_s1_pixel <= 1'b0;
            r_s1_hsync <= 1'b0;
            r_s1_vsync <= 1'b0;
            r_rgb      <= '0;
            r_hsync    <= 1'b0;
            r_vsync    <= 1'b0;
        end else if (i_ce_pix) begin
            r_s1_color <= i_color;
            r_s1_pixel <= i_pixel;
            r_s1_hsync <= i_hsync;
            r_s1_vsync <= i_vsync;
            // r_s1_vsync holds the previous strobe's vsync, so this is the rising edge.
            if (i_vsync && !r_s1_vsync && (32'(i_bank_sel) < BANKS)) begin
                r_bank <= i_bank_sel;
            end
            r_rgb   <= w_rgb_next;
            r_hsync <= r_s1_hsync;
            r_vsync <= r_s1_vsync;
        end
    end

    assign o_rgb   = r_rgb;
    assign o_hsync = r_hsync;
    assign o_vsync = r_vsync;

endmodule

// File: tb/tb_palette_stage.sv
// Directed bench for palette_stage with default parameters (16 entries, 6-bit
// channels, 2 banks). Expected colours are hand-computed constants.
module tb_palette_stage;

    logic        clk;
    logic        rst;
    logic        ce_pix;
    logic        pixel;
    logic [3:0]  color;
    logic        hsync;
    logic        vsync;
    logic        mono;
    logic        bank_sel;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_bank;
    logic [3:0]  wr_addr;
    logic [17:0] wr_data;
    logic [17:0] rgb;
    logic        hsync_o;
    logic        vsync_o;
    logic        init_done;

    int n_vec;
    int n_err;
    int n_clk;
    logic rdy_bad;
    logic rgb_bad;

    // Expected palette entries {R,G,B}
    localparam logic [17:0] C5    = {6'h14, 6'h14, 6'h14};
    localparam logic [17:0] C2    = {6'h08, 6'h08, 6'h08};
    localparam logic [17:0] C3    = {6'h0C, 6'h0C, 6'h0C};
    localparam logic [17:0] C7    = {6'h1C, 6'h1C, 6'h1C};
    localparam logic [17:0] E3    = {6'h3F, 6'h00, 6'h2A};
    localparam logic [17:0] E4    = {6'h3F, 6'h15, 6'h00};
    localparam logic [17:0] E4M   = {6'h15, 6'h15, 6'h15};
    localparam logic [17:0] B1E2  = {6'h01, 6'h02, 6'h03};
    localparam logic [17:0] B1E7  = {6'h11, 6'h22, 6'h33};

    palette_stage dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ce_pix    (ce_pix),
        .i_pixel     (pixel),
        .i_color     (color),
        .i_hsync     (hsync),
        .i_vsync     (vsync),
        .i_mono      (mono),
        .i_bank_sel  (bank_sel),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_bank   (wr_bank),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_rgb       (rgb),
        .o_hsync     (hsync_o),
        .o_vsync     (vsync_o),
        .o_init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pal_write(input logic b, input logic [3:0] a, input logic [17:0] d);
        wr_valid = 1'b1;
        wr_bank  = b;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // Count clocks from reset release until init_done, bounded.
    task automatic wait_init(output int n, output logic rdy_b, output logic rgb_b);
        n     = 0;
        rdy_b = 1'b0;
        rgb_b = 1'b0;
        while (!init_done && n < 100) begin
            if (wr_ready) rdy_b = 1'b1;
            if (rgb != 18'h0) rgb_b = 1'b1;
            tick();
            n++;
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        ce_pix   = 1'b0;
        pixel    = 1'b0;
        color    = 4'h0;
        hsync    = 1'b0;
        vsync    = 1'b0;
        mono     = 1'b0;
        bank_sel = 1'b0;
        wr_valid = 1'b0;
        wr_bank  = 1'b0;
        wr_addr  = 4'h0;
        wr_data  = 18'h0;
        tick();
        tick();
        check("rst_init_done", init_done, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rgb", rgb, 0);
        check("rst_hsync_o", hsync_o, 0);
        check("rst_vsync_o", vsync_o, 0);

        // Drive a live pixel and a write request during init; both must be ignored.
        ce_pix   = 1'b1;
        pixel    = 1'b1;
        color    = 4'd5;
        wr_valid = 1'b1;
        wr_bank  = 1'b0;
        wr_addr  = 4'd5;
        wr_data  = 18'h3FFFF;
        rst      = 1'b0;
        wait_init(n_clk, rdy_bad, rgb_bad);
        wr_valid = 1'b0;
        pixel    = 1'b0;
        color    = 4'd0;
        check("init_clocks", n_clk, 32);
        check("init_wr_ready_low", rdy_bad, 0);
        check("init_rgb_black", rgb_bad, 0);

        // Two-strobe latency for colour and hsync.
        tick();
        tick();
        check("blank_rgb", rgb, 0);
        color = 4'd5;
        pixel = 1'b1;
        hsync = 1'b1;
        tick();
        check("lat1_rgb", rgb, 0);
        check("lat1_hsync", hsync_o, 0);
        hsync = 1'b0;
        tick();
        check("lat2_rgb", rgb, C5);
        check("lat2_hsync", hsync_o, 1);
        tick();
        check("hsync_pulse_end", hsync_o, 0);

        // Host writes, mono and pixel blanking.
        check("wr_ready_run", wr_ready, 1);
        pal_write(1'b0, 4'd3, E3);
        pal_write(1'b0, 4'd4, E4);
        color = 4'd3;
        tick();
        tick();
        check("wr_entry3", rgb, E3);
        mono = 1'b1;
        tick();
        check("mono_entry3", rgb, 0);
        color = 4'd4;
        tick();
        tick();
        check("mono_entry4", rgb, E4M);
        mono  = 1'b0;
        pixel = 1'b0;
        tick();
        check("pixel_lat", rgb, E4);
        tick();
        check("pixel_blank", rgb, 0);

        // Strobe every 4th clock: stage 1 samples only on strobes.
        for (int i = 0; i < 12; i++) begin
            ce_pix = (i % 4 == 0);
            if (i == 0) begin
                color = 4'd5;
                pixel = 1'b1;
                hsync = 1'b1;
            end
            if (i == 1) begin
                color = 4'd3;
                hsync = 1'b0;
            end
            tick();
            check("ce_rgb", rgb, (i < 4) ? 18'h0 : ((i < 8) ? C5 : E3));
            check("ce_hsync", hsync_o, (i >= 4 && i < 8) ? 1 : 0);
        end
        ce_pix = 1'b1;

        // Bank switch waits for a vsync rising edge.
        pal_write(1'b1, 4'd2, B1E2);
        bank_sel = 1'b1;
        color    = 4'd2;
        pixel    = 1'b1;
        tick();
        tick();
        check("bank0_hold", rgb, C2);
        tick();
        tick();
        check("bank0_hold2", rgb, C2);
        vsync = 1'b1;
        tick();
        check("bank_edge1", rgb, C2);
        tick();
        check("bank_switch", rgb, B1E2);
        check("vsync_out", vsync_o, 1);
        bank_sel = 1'b0;
        tick();
        tick();
        check("bank_vsync_level", rgb, B1E2);
        vsync = 1'b0;
        tick();
        tick();

        // Write and lookup of the same entry on one edge: old value first.
        color = 4'd7;
        tick();
        pal_write(1'b1, 4'd7, B1E7);
        check("rdfirst_old", rgb, C7);
        tick();
        check("rdfirst_new", rgb, B1E7);

        // Asynchronous reset, then reset again mid-init.
        rst = 1'b1;
        #1;
        check("async_rst_done", init_done, 0);
        check("async_rst_rgb", rgb, 0);
        check("async_rst_vsync", vsync_o, 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("midinit_not_done", init_done, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init(n_clk, rdy_bad, rgb_bad);
        check("reinit_clocks", n_clk, 32);
        check("reinit_wr_ready_low", rdy_bad, 0);
        color = 4'd3;
        pixel = 1'b1;
        tick();
        tick();
        check("reinit_default3", rgb, C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
